// File: rtl/ack_ram_if.sv
// ack_ram_if - request/acknowledge memory bus between a requester (ALU memory
// port) and ack_ram.
//   master : drives ramAddress, ramOut, readReq, writeReq;
//            receives ramValue, readAck, writeAck, busy, accessError
//   slave  : the mirror image, used by the memory
// Parameters: DATA_BYTES (bytes per word), ADDR_WIDTH (byte-address width).
interface ack_ram_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ramAddress;
  logic [DATA_BYTES*8-1:0] ramOut;
  logic                    readReq;
  logic                    writeReq;
  logic [DATA_BYTES*8-1:0] ramValue;
  logic                    readAck;
  logic                    writeAck;
  logic                    busy;
  logic                    accessError;

  modport master (
    output ramAddress, ramOut, readReq, writeReq,
    input  ramValue, readAck, writeAck, busy, accessError
  );

  modport slave (
    input  ramAddress, ramOut, readReq, writeReq,
    output ramValue, readAck, writeAck, busy, accessError
  );
endinterface

// File: rtl/ack_ram.sv
// ack_ram - byte-addressed little-endian memory with a request/acknowledge
// handshake and a configurable number of wait cycles per access.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; clears control and ramValue, never storage
//   bus   : ack_ram_if.slave
//             ramAddress/ramOut/readReq/writeReq in,
//             ramValue/readAck/writeAck/busy/accessError out
//
// Parameters: DATA_BYTES, ADDR_WIDTH, DEPTH (bytes, power of two), LATENCY (0..255).
//
// Optional feature: define ACK_RAM_BOUNDS_CHECK_EN to flag accesses with
// A + DATA_BYTES > DEPTH. Such an access still handshakes normally, pulses
// accessError with its ack, writes nothing and reads back zero. Without the
// macro every access wraps modulo DEPTH and accessError stays 0.
module ack_ram #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int LATENCY    = 0
) (
  input  logic     clk,
  input  logic     reset,
  ack_ram_if.slave bus
);

  localparam int DW = DATA_BYTES * 8;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic                  op_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0]         wdata_q;
  logic [DW-1:0]         ramValue_q;
  logic                  readAck_q;
  logic                  writeAck_q;
  logic                  busy_q;
  logic                  accessError_q;

  logic [7:0]            mem [DEPTH];

  logic [AW-1:0]         idx [DATA_BYTES];
  logic [DW-1:0]         rd_word;
  logic                  oor;
  logic                  accept;
  logic                  complete;
  logic                  mem_we;

  // Byte k of the word lives at (A+k) mod DEPTH; truncating to AW bits
  // gives the wrap across the top of memory for free.
  always_comb begin
    idx     = '{default: '0};
    rd_word = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      idx[k]             = addr_q[AW-1:0] + AW'(k);
      rd_word[8*k +: 8]  = mem[idx[k]];
    end
  end

`ifdef ACK_RAM_BOUNDS_CHECK_EN
  // One extra bit so A + DATA_BYTES cannot overflow for addresses near 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] BYTES_X = (ADDR_WIDTH+1)'(DATA_BYTES);
  assign oor = ({1'b0, addr_q} + BYTES_X) > DEPTH_X;
`else
  assign oor = 1'b0;
  // Address bits above the storage index only matter for the bounds check.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[ADDR_WIDTH-1:AW];
`endif

  assign accept   = (state_q == S_IDLE) && (bus.writeReq || bus.readReq);
  assign complete = (state_q == S_WAIT) && (cnt_q == 8'd0);
  // Gating with reset makes an access abandoned by reset leave storage untouched.
  assign mem_we   = complete && op_wr_q && !oor && !reset;

  // Storage: no reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        mem[idx[k]] <= wdata_q[8*k +: 8];
      end
    end
  end

  // Request capture: address, data and op are frozen at acceptance, so
  // bus changes during WAIT are invisible. Write wins over read.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_q <= bus.writeReq;
      addr_q  <= bus.ramAddress;
      wdata_q <= bus.ramOut;
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      ramValue_q    <= '0;
      readAck_q     <= 1'b0;
      writeAck_q    <= 1'b0;
      busy_q        <= 1'b0;
      accessError_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q   <= 8'(LATENCY);
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            if (op_wr_q) begin
              writeAck_q <= 1'b1;
            end else begin
              readAck_q  <= 1'b1;
              ramValue_q <= oor ? '0 : rd_word;
            end
            accessError_q <= oor;
            state_q       <= S_ACK;
          end
        end
        S_ACK: begin
          // Turnaround cycle: requests are ignored here so a request still
          // high during the ack is not served twice.
          readAck_q     <= 1'b0;
          writeAck_q    <= 1'b0;
          accessError_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ramValue    = ramValue_q;
  assign bus.readAck     = readAck_q;
  assign bus.writeAck    = writeAck_q;
  assign bus.busy        = busy_q;
  assign bus.accessError = accessError_q;

endmodule

// File: tb/tb_ack_ram.sv
module tb_ack_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rreq;
  logic        wreq;

  ack_ram_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) if0 ();
  ack_ram_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) if3 ();
  ack_ram_if #(.DATA_BYTES(4), .ADDR_WIDTH(32)) if5 ();

  ack_ram #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH(2048), .LATENCY(0))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  ack_ram #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH(2048), .LATENCY(3))
    u3 (.clk(clk), .reset(reset), .bus(if3));
  ack_ram #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH(2048), .LATENCY(5))
    u5 (.clk(clk), .reset(reset), .bus(if5));

  // Shared requester signals, steered to the selected instance only.
  assign if0.ramAddress = addr;
  assign if0.ramOut     = wdata;
  assign if0.readReq    = rreq && (sel == 2'd0);
  assign if0.writeReq   = wreq && (sel == 2'd0);
  assign if3.ramAddress = addr;
  assign if3.ramOut     = wdata;
  assign if3.readReq    = rreq && (sel == 2'd1);
  assign if3.writeReq   = wreq && (sel == 2'd1);
  assign if5.ramAddress = addr;
  assign if5.ramOut     = wdata;
  assign if5.readReq    = rreq && (sel == 2'd2);
  assign if5.writeReq   = wreq && (sel == 2'd2);

  logic [31:0] o_val;
  logic        o_rack, o_wack, o_busy, o_err;
  always_comb begin
    case (sel)
      2'd1:    {o_val, o_rack, o_wack, o_busy, o_err} = {if3.ramValue, if3.readAck, if3.writeAck, if3.busy, if3.accessError};
      2'd2:    {o_val, o_rack, o_wack, o_busy, o_err} = {if5.ramValue, if5.readAck, if5.writeAck, if5.busy, if5.accessError};
      default: {o_val, o_rack, o_wack, o_busy, o_err} = {if0.ramValue, if0.readAck, if0.writeAck, if0.busy, if0.accessError};
    endcase
  end

  typedef struct packed {
    logic        is_wr;
    logic [31:0] val;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ack and compares.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (o_rack || o_wack) begin
        chk("ack_gap", 64'(prev_ack), 64'd0);
        chk("ack_expected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("ack_kind", 64'({o_rack, o_wack}), e.is_wr ? 64'd1 : 64'd2);
          if (!e.is_wr) chk("read_data", 64'(o_val), 64'(e.val));
          chk("access_error", 64'(o_err), 64'(e.err));
        end
      end else if (o_err) begin
        chk("stray_error", 64'(o_err), 64'd0);
      end
    end
    prev_ack = o_rack || o_wack;
  end

  // One complete access: drive, push expectation, time the ack, release.
  task automatic access(input logic is_wr, input logic is_rd, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input logic [31:0] ev,
                        input logic eerr, input string name);
    int n;
    int busy_n;
    @(negedge clk);
    addr  = a;
    wdata = d;
    wreq  = is_wr;
    rreq  = is_rd;
    q.push_back('{is_wr, ev, eerr});
    @(posedge clk); #1;
    n      = 0;
    busy_n = o_busy ? 1 : 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (o_busy) busy_n++;
      if (o_rack || o_wack) break;
    end
    rreq = 1'b0;
    wreq = 1'b0;
    chk($sformatf("%s_latency", name), 64'(n), 64'(lat + 1));
    chk($sformatf("%s_busy_cycles", name), 64'(busy_n), 64'(lat + 2));
    @(posedge clk); #1;
    chk($sformatf("%s_busy_low", name), 64'(o_busy), 64'd0);
  endtask

  localparam int NONE = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 2'd0; addr = '0; wdata = '0; rreq = 1'b0; wreq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_L0", 64'({if0.ramValue, if0.readAck, if0.writeAck, if0.busy, if0.accessError}), 64'd0);
    chk("reset_outs_L3", 64'({if3.ramValue, if3.readAck, if3.writeAck, if3.busy, if3.accessError}), 64'd0);
    chk("reset_outs_L5", 64'({if5.ramValue, if5.readAck, if5.writeAck, if5.busy, if5.accessError}), 64'd0);
    reset = 1'b0;

    // LATENCY=0 instance
    sel = 2'd0;
    access(1, 0, 32'h14, 32'h0000_0000, 0, 32'h0, 1'b0, "clr14");
    access(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, "wr10");
    access(0, 1, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, "rd10");
    access(0, 1, 32'h13, 32'h0, 0, 32'h0000_00DE, 1'b0, "rd13");
    // Both requests: write wins, the read is dropped.
    access(1, 1, 32'h20, 32'h1234_5678, 0, 32'h0, 1'b0, "both20");
    access(0, 1, 32'h20, 32'h0, 0, 32'h1234_5678, 1'b0, "rd20");

    // Held read for 10 edges: accepted on edges 1,4,7,10 -> four acks.
    @(negedge clk);
    addr = 32'h20;
    rreq = 1'b1;
    repeat (4) q.push_back('{1'b0, 32'h1234_5678, 1'b0});
    repeat (10) @(posedge clk);
    #1 rreq = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("held_all_acked", 64'(q.size()), 64'd0);

    // Top of memory, with the wrap region pre-cleared.
    access(1, 0, 32'd0,    32'h0, 0, 32'h0, 1'b0, "clr0");
    access(1, 0, 32'd2044, 32'h0, 0, 32'h0, 1'b0, "clr2044");
`ifdef ACK_RAM_BOUNDS_CHECK_EN
    access(1, 0, 32'd2046, 32'hAABB_CCDD, 0, 32'h0, 1'b1, "wr2046");
    chk("value_held_after_write", 64'(o_val), 64'h1234_5678);
    access(0, 1, 32'd2044, 32'h0, 0, 32'h0000_0000, 1'b0, "rd2044");
    access(0, 1, 32'd0,    32'h0, 0, 32'h0000_0000, 1'b0, "rd0");
    access(0, 1, 32'd2046, 32'h0, 0, 32'h0000_0000, 1'b1, "rd2046");
`else
    access(1, 0, 32'd2046, 32'hAABB_CCDD, 0, 32'h0, 1'b0, "wr2046");
    chk("value_held_after_write", 64'(o_val), 64'h1234_5678);
    access(0, 1, 32'd2044, 32'h0, 0, 32'hCCDD_0000, 1'b0, "rd2044");
    access(0, 1, 32'd0,    32'h0, 0, 32'h0000_AABB, 1'b0, "rd0");
    access(0, 1, 32'd2046, 32'h0, 0, 32'hAABB_CCDD, 1'b0, "rd2046");
`endif

    // LATENCY=3 instance: unaligned read
    sel = 2'd1;
    access(1, 0, 32'h14, 32'h0, 3, 32'h0, 1'b0, "L3_clr14");
    access(1, 0, 32'h10, 32'hDEAD_BEEF, 3, 32'h0, 1'b0, "L3_wr10");
    access(0, 1, 32'h11, 32'h0, 3, 32'h00DE_ADBE, 1'b0, "L3_rd11");

    // LATENCY=5 instance: reset abandons an in-flight write
    sel = 2'd2;
    access(1, 0, 32'h40, 32'h1122_3344, 5, 32'h0, 1'b0, "L5_wr40");
    access(0, 1, 32'h40, 32'h0, 5, 32'h1122_3344, 1'b0, "L5_rd40");
    @(negedge clk);
    addr  = 32'h40;
    wdata = 32'hFFFF_FFFF;
    wreq  = 1'b1;
    @(posedge clk);            // acceptance edge N
    @(negedge clk);
    chk("mid_busy", 64'(o_busy), 64'd1);
    @(negedge clk);            // after N+1
    reset = 1'b1;
    wreq  = 1'b0;
    @(posedge clk);            // reset sampled at N+2
    @(negedge clk);
    chk("mid_reset_outs", 64'({o_val, o_rack, o_wack, o_busy, o_err}), 64'd0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    access(0, 1, 32'h40, 32'h0, 5, 32'h1122_3344, 1'b0, "L5_rd40_after_reset");

    repeat (2) @(posedge clk);
    #1 chk("queue_drained", 64'(q.size()), 64'(NONE));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ack_ram.md
# ack_ram

Parametrised byte-addressed memory with a request/acknowledge handshake, serving the ALU's `readReq`/`writeReq` bus. It generalises the fixed 32-bit, zero-wait memory to configurable word width, depth and access latency. It also adds a busy indication and optional out-of-range detection. It sits between the ALU memory port and on-chip storage, and is synthesizable.

## Interface
- `DATA_BYTES`, 4, bytes per word; data width is `DATA_BYTES*8`.
- `ADDR_WIDTH`, 32, byte-address width.
- `DEPTH`, 2048, storage size in bytes; must be a power of two and ≥ `DATA_BYTES`.
- `LATENCY`, 0, extra wait cycles inserted before each access completes (0..255).

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ramAddress` in `ADDR_WIDTH`: byte address of the access; unaligned addresses are allowed.
- `ramOut` in `DATA_BYTES*8`: write data from the requester.
- `readReq` in 1: read request, level.
- `writeReq` in 1: write request, level.
- `ramValue` out `DATA_BYTES*8`: read data, valid while `readAck`=1 and held afterwards.
- `readAck` out 1: one-cycle pulse, read done.
- `writeAck` out 1: one-cycle pulse, write committed.
- `busy` out 1: high in WAIT and ACK states.
- `accessError` out 1: one-cycle pulse coincident with an ack for an out-of-range access.

## Operation
- States: IDLE, WAIT, ACK.
- **IDLE**
  - On an edge with `writeReq`=1, capture address and write data, op=write.
  - Otherwise, on an edge with `readReq`=1, capture address, op=read.
  - Write has priority when both requests are high; the read is not queued.
  - Load the wait counter with `LATENCY` and go to WAIT.
- **WAIT**
  - If the counter is nonzero, decrement it.
  - If the counter is zero, perform the access, assert the matching ack (and `accessError` if applicable), and go to ACK.
- **ACK**
  - Drop the acks and `accessError`, then return to IDLE.
  - Requests present on this edge are ignored; this gives a one-cycle turnaround so a still-high request is not double-served.
- **Data layout:** little-endian. Byte `k` of the word (bits `8k+7:8k`) maps to address `A+k`, for k = 0..`DATA_BYTES`-1.
- **Address wrap:** each byte index is `(A+k) mod DEPTH`, using the low `clog2(DEPTH)` bits, so an access straddling the top of memory wraps to address 0.
- **Address and data capture:** both are captured at acceptance. Input changes during WAIT have no effect.
- **Read data:** `ramValue` updates only on read completion. Writes and errors leave it unchanged.
- **Reset values:** state=IDLE, counter=0, `ramValue`=0, `readAck`=0, `writeAck`=0, `busy`=0, `accessError`=0.
- **Reset mid-operation:** the in-flight access is abandoned. No ack is issued and no byte is written. Storage contents are never cleared by reset.

## Timing
- Request sampled at edge N in IDLE → ack high after edge N+1+`LATENCY` for exactly one cycle.
- With `LATENCY`=0, ack rises one edge after acceptance.
- Earliest next acceptance is edge N+3+`LATENCY`.
- A write is visible to a read accepted at any later edge.
- `busy` rises after edge N and falls after edge N+2+`LATENCY`.
- Requester rule: hold the request until the ack is seen, then deassert it in the ack cycle. A request still high in IDLE after ACK starts a new access.

## Configuration
- `ACK_RAM_BOUNDS_CHECK_EN` defined:
  - An access is out of range when `A + DATA_BYTES > DEPTH`, computed at `ADDR_WIDTH`+1 bits so it cannot overflow.
  - An out-of-range access still follows the normal handshake and timing, with the ack pulse plus `accessError`=1.
  - A read returns `ramValue`=0; a write modifies no bytes.
- Not defined:
  - All addresses wrap modulo `DEPTH` as described above.
  - `accessError` is tied to 0.

## Test plan
- **Write then read, 32-bit word.** Defaults; write 0xDEADBEEF to address 0x10, then read 0x10 → `writeAck` pulse, then `readAck` pulse with `ramValue`=0xDEADBEEF. Byte 0x10 holds 0xEF and byte 0x13 holds 0xDE.
- **Latency and unaligned read.** `LATENCY`=3; read address 0x11 after the first test → ack exactly 4 edges after acceptance, `busy` high for 5 cycles, `ramValue`=0x00DEADBE.
- **Simultaneous requests.** `readReq`=`writeReq`=1 at address 0x20 with data 0x12345678 → only `writeAck` pulses. A subsequent read of 0x20 returns 0x12345678.
- **Held request.** `readReq` held high for 10 cycles, `LATENCY`=0 → `readAck` pulses every 3 cycles; no two consecutive ack cycles.
- **Top-of-memory access.** Write 0xAABBCCDD to address 2046 with `DEPTH`=2048.
  - Macro undefined: bytes 2046, 2047, 0 and 1 receive 0xDD, 0xCC, 0xBB and 0xAA.
  - Macro defined: `writeAck` and `accessError` pulse together, and memory is unchanged.
- **Reset mid-access.** `LATENCY`=5; accept a write of 0xFFFFFFFF at 0x40, assert `reset` 2 cycles later → no ack, all outputs 0, and a read of 0x40 returns its prior value.
